// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller and its S-memory mux.
package rc4_pkg;

  localparam int KEY_W = 24;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    SEL_INIT = 2'd0,
    SEL_KSA  = 2'd1,
    SEL_DEC  = 2'd2,
    SEL_NONE = 2'd3
  } s_sel_e;

  // Plaintext alphabet: lowercase letters and space.
  function automatic logic is_text_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/rc4_plaintext_checker.sv
// Counts snooped decrypt writes and flags any byte outside the plaintext alphabet.
module rc4_plaintext_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       wren,
  input  logic [7:0] data,
  output logic       ok
);

  logic [5:0] count_reg;
  logic       bad_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
      bad_reg   <= 1'b0;
    end else if (enable && wren) begin
      // Saturate so an over-long message can never wrap back onto MSG_LEN.
      if (count_reg != 6'd63) begin
        count_reg <= count_reg + 6'd1;
      end
      if (!is_text_char(data)) begin
        bad_reg <= 1'b1;
      end
    end
  end

  assign ok = !bad_reg && (count_reg == 6'(MSG_LEN));

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Sequences S-init, KSA and decrypt for each candidate key and steps the key until plaintext is valid.
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
  parameter int               MSG_LEN   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             found,
  output logic             fail,
  output logic [KEY_W-1:0] key_out,
  output logic [1:0]       s_sel,
  output logic             init_start,
  output logic             ksa_start,
  output logic             dec_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             dec_done,
  output logic             init_done_ack,
  output logic             ksa_done_ack,
  output logic             dec_done_ack,
  input  logic             d_wren_in,
  input  logic [7:0]       d_data_in
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_DEC_GO,
    ST_DEC_WAIT,
    ST_CHECK,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } state_e;

  state_e           state_reg;
  s_sel_e           s_sel_reg;
  logic [KEY_W-1:0] key_reg;
  logic             found_reg;
  logic             fail_reg;
  logic             init_start_reg;
  logic             ksa_start_reg;
  logic             dec_start_reg;
  logic             init_ack_reg;
  logic             ksa_ack_reg;
  logic             dec_ack_reg;
  logic             plain_ok;

  rc4_plaintext_checker #(
    .MSG_LEN(MSG_LEN)
  ) u_checker (
    .clk   (clk),
    .reset (reset),
    .clear (state_reg == ST_DEC_GO),
    .enable(state_reg == ST_DEC_WAIT),
    .wren  (d_wren_in),
    .data  (d_data_in),
    .ok    (plain_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      s_sel_reg      <= SEL_NONE;
      key_reg        <= KEY_START;
      found_reg      <= 1'b0;
      fail_reg       <= 1'b0;
      init_start_reg <= 1'b0;
      ksa_start_reg  <= 1'b0;
      dec_start_reg  <= 1'b0;
      init_ack_reg   <= 1'b0;
      ksa_ack_reg    <= 1'b0;
      dec_ack_reg    <= 1'b0;
    end else begin
      init_start_reg <= 1'b0;
      ksa_start_reg  <= 1'b0;
      dec_start_reg  <= 1'b0;
      init_ack_reg   <= 1'b0;
      ksa_ack_reg    <= 1'b0;
      dec_ack_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FOUND, ST_FAIL: begin
          if (start) begin
            key_reg   <= KEY_START;
            found_reg <= 1'b0;
            fail_reg  <= 1'b0;
            state_reg <= ST_INIT_GO;
          end
        end
        ST_INIT_GO: begin
          s_sel_reg      <= SEL_INIT;
          init_start_reg <= 1'b1;
          state_reg      <= ST_INIT_WAIT;
        end
        ST_INIT_WAIT: begin
          if (init_done) begin
            init_ack_reg <= 1'b1;
            state_reg    <= ST_KSA_GO;
          end
        end
        ST_KSA_GO: begin
          s_sel_reg     <= SEL_KSA;
          ksa_start_reg <= 1'b1;
          state_reg     <= ST_KSA_WAIT;
        end
        ST_KSA_WAIT: begin
          if (ksa_done) begin
            ksa_ack_reg <= 1'b1;
            state_reg   <= ST_DEC_GO;
          end
        end
        ST_DEC_GO: begin
          s_sel_reg     <= SEL_DEC;
          dec_start_reg <= 1'b1;
          state_reg     <= ST_DEC_WAIT;
        end
        ST_DEC_WAIT: begin
          if (dec_done) begin
            dec_ack_reg <= 1'b1;
            s_sel_reg   <= SEL_NONE;
            state_reg   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Range end is tested before any increment, so the key never passes KEY_END.
          if (plain_ok) begin
            found_reg <= 1'b1;
            state_reg <= ST_FOUND;
          end else if (key_reg == KEY_END) begin
            fail_reg  <= 1'b1;
            state_reg <= ST_FAIL;
          end else begin
            state_reg <= ST_NEXT_KEY;
          end
        end
        ST_NEXT_KEY: begin
          key_reg   <= key_reg + KEY_W'(1);
          state_reg <= ST_INIT_GO;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy          = !(state_reg inside {ST_IDLE, ST_FOUND, ST_FAIL});
  assign found         = found_reg;
  assign fail          = fail_reg;
  assign key_out       = key_reg;
  assign s_sel         = s_sel_reg;
  assign init_start    = init_start_reg;
  assign ksa_start     = ksa_start_reg;
  assign dec_start     = dec_start_reg;
  assign init_done_ack = init_ack_reg;
  assign ksa_done_ack  = ksa_ack_reg;
  assign dec_done_ack  = dec_ack_reg;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench: two controllers (full range and a single-key range) driven by simple engine models.
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start_v = 2'b00;
  logic [1:0] busy_v, found_v, fail_v;
  logic [1:0] init_start_v, ksa_start_v, dec_start_v;
  logic [1:0] init_done_v, ksa_done_v, dec_done_v;
  logic [1:0] init_ack_v, ksa_ack_v, dec_ack_v;
  logic [1:0] wren_v;
  logic [23:0] key_v [2];
  logic [1:0]  sel_v [2];
  logic [7:0]  data_v [2];

  // Decrypt model configuration per channel
  int       n_writes [2];
  int       bad_keys [2];
  int       bad_pos  [2];
  logic [7:0] bad_val [2];
  bit       coincide [2];

  int n_cmp = 0;
  int n_bad = 0;
  int n_init [2];
  int n_ksa  [2];
  int n_dec  [2];

  rc4_key_search_ctrl dut (
    .clk(clk), .reset(reset), .start(start_v[0]), .busy(busy_v[0]),
    .found(found_v[0]), .fail(fail_v[0]), .key_out(key_v[0]), .s_sel(sel_v[0]),
    .init_start(init_start_v[0]), .ksa_start(ksa_start_v[0]), .dec_start(dec_start_v[0]),
    .init_done(init_done_v[0]), .ksa_done(ksa_done_v[0]), .dec_done(dec_done_v[0]),
    .init_done_ack(init_ack_v[0]), .ksa_done_ack(ksa_ack_v[0]), .dec_done_ack(dec_ack_v[0]),
    .d_wren_in(wren_v[0]), .d_data_in(data_v[0])
  );

  rc4_key_search_ctrl #(
    .KEY_START(24'h00000A), .KEY_END(24'h00000A), .MSG_LEN(32)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .busy(busy_v[1]),
    .found(found_v[1]), .fail(fail_v[1]), .key_out(key_v[1]), .s_sel(sel_v[1]),
    .init_start(init_start_v[1]), .ksa_start(ksa_start_v[1]), .dec_start(dec_start_v[1]),
    .init_done(init_done_v[1]), .ksa_done(ksa_done_v[1]), .dec_done(dec_done_v[1]),
    .init_done_ack(init_ack_v[1]), .ksa_done_ack(ksa_ack_v[1]), .dec_done_ack(dec_ack_v[1]),
    .d_wren_in(wren_v[1]), .d_data_in(data_v[1])
  );

  // Engine models: init/ksa raise done 3 cycles after start; decrypt writes n_writes bytes then done.
  int init_cnt [2];
  int ksa_cnt  [2];
  int wcnt     [2];
  bit drun     [2];
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        init_cnt[c] <= 0; ksa_cnt[c] <= 0; wcnt[c] <= 0; drun[c] <= 1'b0;
        init_done_v[c] <= 1'b0; ksa_done_v[c] <= 1'b0; dec_done_v[c] <= 1'b0;
        wren_v[c] <= 1'b0; data_v[c] <= 8'h00;
      end else begin
        if (init_ack_v[c]) init_done_v[c] <= 1'b0;
        if (init_start_v[c]) init_cnt[c] <= 1;
        else if (init_cnt[c] == 3) begin init_done_v[c] <= 1'b1; init_cnt[c] <= 0; end
        else if (init_cnt[c] > 0) init_cnt[c] <= init_cnt[c] + 1;

        if (ksa_ack_v[c]) ksa_done_v[c] <= 1'b0;
        if (ksa_start_v[c]) ksa_cnt[c] <= 1;
        else if (ksa_cnt[c] == 3) begin ksa_done_v[c] <= 1'b1; ksa_cnt[c] <= 0; end
        else if (ksa_cnt[c] > 0) ksa_cnt[c] <= ksa_cnt[c] + 1;

        wren_v[c] <= 1'b0;
        if (dec_ack_v[c]) dec_done_v[c] <= 1'b0;
        if (dec_start_v[c]) begin
          drun[c] <= 1'b1; wcnt[c] <= 0;
        end else if (drun[c]) begin
          if (wcnt[c] < n_writes[c]) begin
            wren_v[c] <= 1'b1;
            data_v[c] <= ((int'(key_v[c]) < bad_keys[c]) && (wcnt[c] == bad_pos[c])) ? bad_val[c] : 8'h61;
            wcnt[c] <= wcnt[c] + 1;
            if (coincide[c] && (wcnt[c] == n_writes[c] - 1)) begin
              dec_done_v[c] <= 1'b1; drun[c] <= 1'b0;
            end
          end else begin
            dec_done_v[c] <= 1'b1; drun[c] <= 1'b0;
          end
        end
      end
    end
  end

  // Handshake monitor: s_sel vs running engine, single-cycle pulses, ack on first done cycle.
  bit   act     [2][3];
  bit   prev_st [2][3];
  bit   prev_ak [2][3];
  int   dwait   [2][3];
  logic [2:0] m_st, m_dn, m_ak;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m_st = {dec_start_v[c], ksa_start_v[c], init_start_v[c]};
      m_dn = {dec_done_v[c], ksa_done_v[c], init_done_v[c]};
      m_ak = {dec_ack_v[c], ksa_ack_v[c], init_ack_v[c]};
      for (int e = 0; e < 3; e++) begin
        if (reset) begin
          act[c][e] = 1'b0; prev_st[c][e] = 1'b0; prev_ak[c][e] = 1'b0; dwait[c][e] = 0;
        end else begin
          if (m_st[e]) begin
            if (e == 0) n_init[c]++;
            if (e == 1) n_ksa[c]++;
            if (e == 2) n_dec[c]++;
            n_cmp++;
            if (prev_st[c][e]) begin
              n_bad++;
              $display("FAIL start_pulse ch%0d eng%0d: start high 2 cycles, want 1", c, e);
            end
          end
          if (m_ak[e]) begin
            n_cmp++;
            if (!m_dn[e] || prev_ak[c][e]) begin
              n_bad++;
              $display("FAIL ack_pulse ch%0d eng%0d: done=%0b prev_ack=%0b, want done=1 prev_ack=0",
                       c, e, m_dn[e], prev_ak[c][e]);
            end
          end
          if (m_dn[e] && !m_ak[e]) dwait[c][e]++;
          else dwait[c][e] = 0;
          if (dwait[c][e] >= 2) begin
            n_cmp++; n_bad++;
            $display("FAIL ack_late ch%0d eng%0d: done unacked for %0d cycles, want ack in 2nd", c, e, dwait[c][e]);
          end
          if (m_st[e]) act[c][e] = 1'b1;
          if (m_ak[e]) act[c][e] = 1'b0;
          if (act[c][e]) begin
            n_cmp++;
            if (sel_v[c] !== 2'(e)) begin
              n_bad++;
              $display("FAIL s_sel ch%0d: got %0d want %0d", c, sel_v[c], e);
            end
          end
          prev_st[c][e] = m_st[e];
          prev_ak[c][e] = m_ak[e];
        end
      end
    end
  end

  task automatic config_ch(input int c, input int nw, input int bk, input int bp,
                           input logic [7:0] bv, input bit co);
    n_writes[c] = nw; bad_keys[c] = bk; bad_pos[c] = bp; bad_val[c] = bv; coincide[c] = co;
  endtask

  task automatic pulse_start(input int c);
    n_init[c] = 0; n_ksa[c] = 0; n_dec[c] = 0;
    start_v[c] = 1'b1;
    @(negedge clk);
    start_v[c] = 1'b0;
  endtask

  task automatic wait_end(input int c, input int limit);
    int k = 0;
    while (!(found_v[c] || fail_v[c]) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!(found_v[c] || fail_v[c])) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_end ch%0d: no found/fail after %0d cycles", c, limit);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if (busy_v[c] !== 1'b0 || found_v[c] !== 1'b0 || fail_v[c] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_flags ch%0d: busy=%0b found=%0b fail=%0b, want 0 0 0", c, busy_v[c], found_v[c], fail_v[c]);
      end
      n_cmp++;
      if (key_v[c] !== ((c == 0) ? 24'h000000 : 24'h00000A)) begin
        n_bad++;
        $display("FAIL reset_key ch%0d: got %h", c, key_v[c]);
      end
      n_cmp++;
      if (sel_v[c] !== 2'd3) begin
        n_bad++;
        $display("FAIL reset_sel ch%0d: got %0d want 3", c, sel_v[c]);
      end
      n_cmp++;
      if ({init_start_v[c], ksa_start_v[c], dec_start_v[c], init_ack_v[c], ksa_ack_v[c], dec_ack_v[c]} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_pulses ch%0d: start/ack outputs not all 0", c);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_single_key();
    config_ch(0, 32, 0, 0, 8'h00, 1'b0);
    pulse_start(0);
    wait_end(0, 3000);
    n_cmp++;
    if (found_v[0] !== 1'b1 || fail_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_flags: found=%0b fail=%0b busy=%0b, want 1 0 0", found_v[0], fail_v[0], busy_v[0]);
    end
    n_cmp++;
    if (key_v[0] !== 24'h000000 || sel_v[0] !== 2'd3) begin
      n_bad++;
      $display("FAIL single_key: key=%h sel=%0d, want 000000 3", key_v[0], sel_v[0]);
    end
    n_cmp++;
    if (n_init[0] != 1 || n_ksa[0] != 1 || n_dec[0] != 1) begin
      n_bad++;
      $display("FAIL single_runs: init=%0d ksa=%0d dec=%0d, want 1 1 1", n_init[0], n_ksa[0], n_dec[0]);
    end
    $display("test_single_key: key=%h found=%0b", key_v[0], found_v[0]);
  endtask

  task automatic test_bad_keys();
    config_ch(0, 32, 3, 5, 8'h7B, 1'b0);
    pulse_start(0);
    wait_end(0, 5000);
    n_cmp++;
    if (found_v[0] !== 1'b1 || key_v[0] !== 24'h000003) begin
      n_bad++;
      $display("FAIL bad_keys: found=%0b key=%h, want 1 000003", found_v[0], key_v[0]);
    end
    n_cmp++;
    if (n_init[0] != 4 || n_dec[0] != 4) begin
      n_bad++;
      $display("FAIL bad_keys_runs: init=%0d dec=%0d, want 4 4", n_init[0], n_dec[0]);
    end
    $display("test_bad_keys: key=%h found=%0b", key_v[0], found_v[0]);
  endtask

  task automatic test_exhaust();
    config_ch(1, 32, 1000, 0, 8'h00, 1'b0);
    pulse_start(1);
    wait_end(1, 2000);
    n_cmp++;
    if (fail_v[1] !== 1'b1 || found_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL exhaust_flags: fail=%0b found=%0b busy=%0b, want 1 0 0", fail_v[1], found_v[1], busy_v[1]);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (key_v[1] !== 24'h00000A || n_init[1] != 1 || n_dec[1] != 1) begin
      n_bad++;
      $display("FAIL exhaust_key: key=%h init=%0d dec=%0d, want 00000A 1 1", key_v[1], n_init[1], n_dec[1]);
    end
    $display("test_exhaust: key=%h fail=%0b", key_v[1], fail_v[1]);
  endtask

  task automatic test_short_msg();
    int k = 0;
    config_ch(0, 31, 0, 0, 8'h00, 1'b0);
    pulse_start(0);
    while (n_dec[0] < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (n_dec[0] < 2 || key_v[0] !== 24'h000001 || found_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL short_reject: dec_runs=%0d key=%h found=%0b, want 2 000001 0", n_dec[0], key_v[0], found_v[0]);
    end
    do_reset();
    config_ch(0, 32, 0, 0, 8'h00, 1'b1);
    pulse_start(0);
    wait_end(0, 3000);
    n_cmp++;
    if (found_v[0] !== 1'b1 || key_v[0] !== 24'h000000 || n_dec[0] != 1) begin
      n_bad++;
      $display("FAIL coincide_accept: found=%0b key=%h dec=%0d, want 1 000000 1", found_v[0], key_v[0], n_dec[0]);
    end
    $display("test_short_msg: coincident write key=%h found=%0b", key_v[0], found_v[0]);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    config_ch(0, 32, 2, 0, 8'h00, 1'b0);
    pulse_start(0);
    while (!(ksa_start_v[0] && key_v[0] == 24'h000001) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_cmp++;
    if (busy_v[0] !== 1'b1 || key_v[0] !== 24'h000001 || sel_v[0] !== 2'd1) begin
      n_bad++;
      $display("FAIL mid_pre: busy=%0b key=%h sel=%0d, want 1 000001 1", busy_v[0], key_v[0], sel_v[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy_v[0] !== 1'b0 || sel_v[0] !== 2'd3 || key_v[0] !== 24'h000000 || found_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%0b sel=%0d key=%h found=%0b, want 0 3 000000 0",
               busy_v[0], sel_v[0], key_v[0], found_v[0]);
    end
    reset = 1'b0;
    @(negedge clk);

    // A second start during the key-1 pass must not restart the search.
    pulse_start(0);
    k = 0;
    while (!(init_start_v[0] && key_v[0] == 24'h000001) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_end(0, 3000);
    n_cmp++;
    if (found_v[0] !== 1'b1 || key_v[0] !== 24'h000002 || n_init[0] != 3) begin
      n_bad++;
      $display("FAIL busy_start: found=%0b key=%h init=%0d, want 1 000002 3", found_v[0], key_v[0], n_init[0]);
    end

    config_ch(0, 32, 0, 0, 8'h00, 1'b0);
    pulse_start(0);
    n_cmp++;
    if (busy_v[0] !== 1'b1 || found_v[0] !== 1'b0 || key_v[0] !== 24'h000000) begin
      n_bad++;
      $display("FAIL restart: busy=%0b found=%0b key=%h, want 1 0 000000", busy_v[0], found_v[0], key_v[0]);
    end
    wait_end(0, 3000);
    n_cmp++;
    if (found_v[0] !== 1'b1 || key_v[0] !== 24'h000000 || n_init[0] != 1) begin
      n_bad++;
      $display("FAIL restart_end: found=%0b key=%h init=%0d, want 1 000000 1", found_v[0], key_v[0], n_init[0]);
    end
    $display("test_reset_mid: restart key=%h found=%0b", key_v[0], found_v[0]);
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      config_ch(c, 32, 0, 0, 8'h00, 1'b0);
      n_init[c] = 0; n_ksa[c] = 0; n_dec[c] = 0;
    end
    test_reset();
    test_single_key();
    test_bad_keys();
    test_exhaust();
    test_short_msg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
